// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end with read-modify-write for sub-word stores.
// Define MEMIF_ALIGN_CHECK_EN to flag misaligned/illegal requests; otherwise addresses are force-aligned.
module mem_access_unit #(
   parameter int WORD = 32,
   parameter int ADDR = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR+1:0]   req_addr,
   input  logic [WORD-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD-1:0]   resp_rdata,
   output logic              resp_err,
   output logic [ADDR-1:0]   mem_a,
   output logic              mem_w,
   output logic [WORD-1:0]   mem_d,
   input  logic [WORD-1:0]   mem_q
);
   typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;
   state_t state, state_nx;
   logic we_r, uns_r, accept, illegal;
   logic [1:0] size_r, size_n;
   logic [ADDR+1:0] addr_r, addr_n;
   logic [WORD-1:0] wdata_r, mask, lane_q, merged, load_ext;
   logic [$clog2(WORD)-1:0] sh;
   assign accept = req_valid && req_ready;
`ifdef MEMIF_ALIGN_CHECK_EN
   assign size_n  = req_size;
   assign addr_n  = req_addr;
   assign illegal = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
   // size 11 collapses to a word; low address bits are cleared to natural alignment
   assign size_n  = (req_size == 2'b11) ? 2'b10 : req_size;
   assign addr_n  = {req_addr[ADDR+1:2], size_n[1] ? 2'b00 : {req_addr[1], req_addr[0] & ~size_n[0]}};
   assign illegal = 1'b0;
`endif
   assign mem_a    = addr_r[ADDR+1:2];
   assign sh       = {addr_r[1:0], 3'b000};
   assign mask     = size_r[0] ? WORD'(16'hFFFF) : WORD'(8'hFF);
   assign merged   = (mem_q & ~(mask << sh)) | ((wdata_r & mask) << sh);
   assign lane_q   = mem_q >> sh;
   assign load_ext = size_r[1] ? mem_q :
                     size_r[0] ? {{(WORD-16){~uns_r & lane_q[15]}}, lane_q[15:0]} :
                                 {{(WORD-8){~uns_r & lane_q[7]}}, lane_q[7:0]};
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         we_r       <= 1'b0;
         uns_r      <= 1'b0;
         size_r     <= 2'b00;
         addr_r     <= '0;
         wdata_r    <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else if (accept) begin
         we_r       <= req_we;
         uns_r      <= req_unsigned;
         size_r     <= size_n;
         addr_r     <= addr_n;
         wdata_r    <= req_wdata;
         resp_err   <= illegal;
         resp_rdata <= '0;
      end else if (state == DATA && !we_r) begin
         resp_rdata <= load_ext;
      end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = !accept ? IDLE : illegal ? RESP : (req_we && size_n == 2'b10) ? WR : RD;
         RD:      state_nx = DATA;
         DATA:    state_nx = RESP;
         WR:      state_nx = RESP;
         RESP:    state_nx = resp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      req_ready  = rst && state == IDLE;
      resp_valid = state == RESP;
      mem_w      = state == WR || (state == DATA && we_r);
      mem_d      = state == WR ? wdata_r : (state == DATA && we_r) ? merged : '0;
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized load/store traffic against a word-array reference model.
module tb_mem_access_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
   logic [1:0] req_size = 2'b00;
   logic [17:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic req_ready, resp_valid, resp_err, mem_w;
   logic [31:0] resp_rdata, mem_d, mem_q;
   logic [15:0] mem_a, last_wa;
   logic [31:0] mem [0:65535];
   logic [31:0] shadow [0:255];
   int checks = 0, failures = 0, wcount = 0;
   logic [31:0] got;
   mem_access_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
   );
   always #5 clk = ~clk;
   // memory output register holds its value across writes
   always @(posedge clk)
      if (mem_w) begin
         mem[mem_a] <= mem_d;
         wcount     <= wcount + 1;
         last_wa    <= mem_a;
      end else mem_q <= mem[mem_a];
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic bit legal(int sz, int a);
`ifdef MEMIF_ALIGN_CHECK_EN
      return sz == 0 || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
`else
      return 1'b1;
`endif
   endfunction
   function automatic int eff_size(int sz);
`ifdef MEMIF_ALIGN_CHECK_EN
      return sz;
`else
      return sz == 3 ? 2 : sz;
`endif
   endfunction
   function automatic logic [31:0] model_load(int nb, bit uns, int ea);
      longint v;
      v = (longint'(shadow[ea / 4]) >> (8 * (ea % 4))) & ((longint'(1) << (8 * nb)) - 1);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
      return 32'(v);
   endfunction
   function automatic logic [31:0] model_store(int nb, int ea, logic [31:0] wd);
      logic [31:0] w = shadow[ea / 4];
      for (int i = 0; i < nb; i++) w[8 * (ea % 4 + i) +: 8] = wd[8 * i +: 8];
      return w;
   endfunction
   task automatic preload(input int wa, input logic [31:0] v);
      mem[wa] = v;
      shadow[wa] = v;
   endtask
   task automatic do_req(input bit we, input int sz, input bit uns, input int a, input logic [31:0] wd,
                         input int stall, output logic [31:0] rd);
      bit ok = legal(sz, a);
      int nb = 1 << eff_size(sz);
      int ea = a - a % nb;
      int lat = !ok ? 1 : (we && nb == 4) ? 2 : 3;
      logic [31:0] exp_rd = (!ok || we) ? 32'h0 : model_load(nb, uns, ea);
      int w0 = wcount, cyc = 1;
      @(negedge clk);
      check("req_ready_idle", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = we; req_size = 2'(sz); req_unsigned = uns;
      req_addr = 18'(a); req_wdata = wd; resp_ready = stall == 0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      while (!resp_valid && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'(lat));
      check("resp_err", {31'b0, resp_err}, {31'b0, !ok});
      check("resp_rdata", resp_rdata, exp_rd);
      rd = resp_rdata;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_valid", {31'b0, resp_valid}, 32'h1);
         check("stall_rdata", resp_rdata, exp_rd);
         check("stall_ready", {31'b0, req_ready}, 32'h0);
         if (i == stall - 1) resp_ready = 1'b1;
      end
      @(negedge clk);
      check("resp_done", {31'b0, resp_valid}, 32'h0);
      if (we && ok) shadow[ea / 4] = model_store(nb, ea, wd);
      check("write_count", 32'(wcount - w0), {31'b0, we && ok});
      if (we && ok) begin
         check("write_addr", {16'b0, last_wa}, 32'(ea / 4));
         check("mem_word", mem[ea / 4], shadow[ea / 4]);
      end
   endtask
   initial begin
      int w0;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      #2 rst = 1'b0;
      #1;
      check("rst_ready", {31'b0, req_ready}, 32'h0);
      check("rst_outs", {29'b0, resp_valid, resp_err, mem_w}, 32'h0);
      check("rst_data", resp_rdata | mem_d | {16'b0, mem_a}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'b0, req_ready}, 32'h1);
      do_req(1, 2, 0, 'h10, 32'hDEADBEEF, 0, got);
      do_req(0, 2, 0, 'h10, 0, 0, got);
      check("word_load_const", got, 32'hDEADBEEF);
      preload('h20 / 4, 32'h11223344);
      do_req(1, 0, 0, 'h22, 32'h000000AA, 0, got);
      check("byte_merge_const", mem['h20 / 4], 32'h11AA3344);
      preload('h30 / 4, 32'h000080FF);
      do_req(0, 0, 0, 'h30, 0, 0, got);
      check("lb_signed", got, 32'hFFFFFFFF);
      do_req(0, 0, 1, 'h30, 0, 0, got);
      check("lb_unsigned", got, 32'h000000FF);
      do_req(0, 1, 0, 'h30, 0, 0, got);
      check("lh_signed", got, 32'hFFFF80FF);
      do_req(0, 2, 0, 'h2, 0, 0, got);
      do_req(0, 2, 0, 'h10, 0, 5, got);
      preload('h40 / 4, 32'h55667788);
      w0 = wcount;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 18'h42; req_wdata = 32'h99;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_store_w", {31'b0, mem_w}, 32'h1);
      rst = 1'b0;
      #1;
      check("abort_w", {31'b0, mem_w}, 32'h0);
      check("abort_outs", {30'b0, resp_valid, resp_err}, 32'h0);
      check("abort_ready", {31'b0, req_ready}, 32'h0);
      check("abort_data", resp_rdata | mem_d | {16'b0, mem_a}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("release_ready", {31'b0, req_ready}, 32'h1);
      check("abort_mem", mem['h40 / 4], 32'h55667788);
      check("abort_wcount", 32'(wcount - w0), 32'h0);
      for (int i = 0; i < 80; i++)
         do_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 255), $urandom, $urandom_range(0, 2), got);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end sitting directly upstream of the 32-bit × 64k-word single-port data memory. Accepts byte-addressed load/store requests from the execute stage, drives the memory's word address, write strobe and write data, and returns extracted, sign- or zero-extended load data. The memory only supports full-word writes, so sub-word stores are done as read-modify-write.

## Interface
- WORD, 32: data width in bits; the memory word width.
- ADDR, 16: word-address width of the memory.
- clk  in  1  rising-edge clock, shared with the memory.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR+2  byte address; [ADDR+1:2] is the word address, [1:0] is the lane.
- req_wdata  in  WORD  store data, right-aligned.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  WORD  load result; 0 for stores and errors.
- resp_err  out  1  request was misaligned or illegal.
- mem_a  out  ADDR  memory word address.
- mem_w  out  1  memory write strobe.
- mem_d  out  WORD  memory write data.
- mem_q  in  WORD  memory read data; valid the cycle after a read edge.

## Operation
- **State machine states:** IDLE, RD, DATA, WR, RESP.
- **Request latch:** when req_valid and req_ready are both high at a rising edge, the block latches the request fields.
- **mem_a** always reflects the latched word address. mem_w and mem_d decode from the state register only.
- **Lane mapping:** little-endian; byte k is bits [8k+7:8k], with k = addr[1:0]. A half uses lanes addr[1]*2 and addr[1]*2+1.
- **Legality:**
  - Byte: any address is legal.
  - Half: requires addr[0]=0.
  - Word: requires addr[1:0]=00.
  - size 11: always illegal.
- **Transitions out of IDLE on accept:**
  - Illegal request → RESP with resp_err=1. No memory access of any kind.
  - Load → RD.
  - Word store → WR.
  - Byte or half store → RD.
- **RD:** mem_w=0. The memory captures mem_q at the end of this cycle. Next state is DATA.
- **DATA, load:** the selected lane(s) are extended to WORD per req_unsigned and registered into resp_rdata. Next state is RESP.
- **DATA, sub-word store:** mem_w=1 and mem_d = mem_q with only the target lane(s) replaced by the low bits of req_wdata. Next state is RESP.
  - mem_q stays stable through this write, because the memory output register does not update on a write.
- **WR:** mem_w=1, mem_d=req_wdata. Next state is RESP.
- **RESP:** resp_valid=1. Return to IDLE at the first edge with resp_ready=1.
  - A new request is accepted no earlier than the following cycle; there is no bypass.
- **Reset:**
  - All outputs are 0 while rst is low: req_ready, resp_valid, resp_err, resp_rdata, mem_w, mem_d, mem_a. State is IDLE.
  - A reset asserted during RD, DATA or WR drops mem_w immediately and aborts the access; no partial write occurs after rst is released.
  - req_ready rises in the first cycle after rst deasserts.

## Timing
- Latency is counted from the accepting edge E0 to the first cycle with resp_valid high:
  - Word store: 2 cycles (write at E1).
  - Load: 3 cycles (memory read at E1, data registered at E2).
  - Sub-word store: 3 cycles (read at E1, merged write at E2).
  - Illegal request: 1 cycle.
- A response stalled by resp_ready=0 holds resp_valid, resp_rdata and resp_err stable, and keeps req_ready=0.
- mem_w is high for exactly one cycle per legal store and never on loads.
- Back-to-back throughput: one request per (latency + 1) cycles when resp_ready is held high.

## Configuration
- MEMIF_ALIGN_CHECK_EN defined:
  - Legality checking as described above.
  - Illegal requests return resp_err=1 with no memory access.
- MEMIF_ALIGN_CHECK_EN undefined:
  - resp_err is tied to 0.
  - Halves ignore addr[0] and words ignore addr[1:0], i.e. the address is forced to natural alignment.
  - size 11 is treated as a word access.

## Test plan
- **Word store, then load:**
  - Stimulus: store size=10, addr=0x0010, wdata=0xDEADBEEF; then load size=10 from the same address.
  - Required: mem_w pulses once with mem_a=0x0004; the load returns 0xDEADBEEF with resp_valid 3 cycles after acceptance.
- **Byte store merge:**
  - Stimulus: word 0x11223344 preloaded at addr 0x20; store byte 0xAA to addr 0x22.
  - Required: the memory word becomes 0x11AA3344; resp_valid arrives 3 cycles after acceptance; mem_w is high only in DATA.
- **Sign and zero extension:**
  - Stimulus: with 0x000080FF at addr 0x30, load byte at 0x30 (signed, then unsigned), then load half at 0x30 (signed).
  - Required: 0xFFFFFFFF, 0x000000FF and 0xFFFF80FF respectively.
- **Misaligned request, with MEMIF_ALIGN_CHECK_EN:**
  - Stimulus: word load at 0x0002.
  - Required: resp_err=1 and resp_rdata=0 one cycle after acceptance; mem_w never asserted.
- **Response backpressure:**
  - Stimulus: hold resp_ready=0 for 5 cycles during a load response.
  - Required: resp_valid and resp_rdata held stable; req_ready stays 0; return to IDLE on the first edge with resp_ready=1.
- **Reset mid-store:**
  - Stimulus: drive rst low during DATA of a byte store to 0x40.
  - Required: mem_w drops immediately; the memory word is unchanged; all outputs are 0; req_ready=1 in the first cycle after release.
